// File: rtl/apb_slave_router.sv
// APB fan-out router: one master port to NO_OF_SLAVES slave ports with registered
// slave-side signals, address-field decode, decode-miss and timeout error responses.
module apb_slave_router #(
   parameter int NO_OF_SLAVES   = 4,
   parameter int ADDR_WIDTH     = 32,
   parameter int DATA_WIDTH     = 32,
   parameter int SLV_SEL_LSB    = 12,
   parameter int TIMEOUT_CYCLES = 16
) (
   input  logic                                 clk,
   input  logic                                 rst_n,
   input  logic                                 m_psel,
   input  logic                                 m_penable,
   input  logic                                 m_pwrite,
   input  logic [ADDR_WIDTH-1:0]                m_paddr,
   input  logic [DATA_WIDTH-1:0]                m_pwdata,
   output logic [DATA_WIDTH-1:0]                m_prdata,
   output logic                                 m_pready,
   output logic                                 m_pslverr,
   output logic [NO_OF_SLAVES-1:0]              s_pselx,
   output logic                                 s_penable,
   output logic                                 s_pwrite,
   output logic [ADDR_WIDTH-1:0]                s_paddr,
   output logic [DATA_WIDTH-1:0]                s_pwdata,
   input  logic [NO_OF_SLAVES*DATA_WIDTH-1:0]   s_prdata,
   input  logic [NO_OF_SLAVES-1:0]              s_pready,
   input  logic [NO_OF_SLAVES-1:0]              s_pslverr,
   output logic [7:0]                           err_count
);

   localparam int IDXW = (NO_OF_SLAVES > 1) ? $clog2(NO_OF_SLAVES) : 1;
   localparam int TCW  = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [IDXW:0]  SLAVES_W = (IDXW + 1)'(NO_OF_SLAVES);
   localparam logic [TCW-1:0] TLIMIT   = TCW'(TIMEOUT_CYCLES);
   localparam bit             TO_EN    = (TIMEOUT_CYCLES != 0);

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_SETUP   = 2'd1;
   localparam logic [1:0] ST_ACCESS  = 2'd2;
   localparam logic [1:0] ST_DEC_ERR = 2'd3;

   logic [1:0]              state_reg,   state_next;
   logic [IDXW-1:0]         idx_reg,     idx_next;
   logic [NO_OF_SLAVES-1:0] sel_reg,     sel_next;
   logic                    penable_reg, penable_next;
   logic                    pwrite_reg,  pwrite_next;
   logic [ADDR_WIDTH-1:0]   paddr_reg,   paddr_next;
   logic [DATA_WIDTH-1:0]   pwdata_reg,  pwdata_next;
   logic [TCW-1:0]          tcnt_reg,    tcnt_next;
   logic [7:0]              err_reg,     err_next;

   logic [IDXW-1:0]         req_idx;
   logic                    req_in_range;
   logic [NO_OF_SLAVES-1:0] req_hit;
   logic [NO_OF_SLAVES-1:0] idx_hit;
   logic                    sel_ready;
   logic                    sel_err;
   logic [DATA_WIDTH-1:0]   sel_rdata;
   logic                    timeout_hit;
   logic                    complete;
   logic                    err_inc;

   assign req_idx      = m_paddr[SLV_SEL_LSB +: IDXW];
   assign req_in_range = ({1'b0, req_idx} < SLAVES_W);

   // Per-slave decode of the incoming request and of the latched target.
   generate
      for (genvar gi = 0; gi < NO_OF_SLAVES; gi++) begin : g_dec
         assign req_hit[gi] = (req_idx == IDXW'(gi));
         assign idx_hit[gi] = (idx_reg == IDXW'(gi));
      end
   endgenerate

   // Only the latched target's response is visible; other slaves are masked out.
   always_comb begin
      sel_rdata = '0;
      for (int k = 0; k < NO_OF_SLAVES; k++) begin
         if (idx_hit[k]) begin
            sel_rdata = s_prdata[k*DATA_WIDTH +: DATA_WIDTH];
         end
      end
   end

   assign sel_ready = |(s_pready & idx_hit);
   assign sel_err   = |(s_pslverr & idx_hit);

   // A slave that answers on the timeout cycle itself wins over the timeout.
   assign timeout_hit = TO_EN && (state_reg == ST_ACCESS) && m_psel && !sel_ready
                        && (tcnt_reg == TLIMIT);
   assign complete    = (state_reg == ST_ACCESS) && m_psel && (sel_ready || timeout_hit);

   always_comb begin
      state_next   = state_reg;
      idx_next     = idx_reg;
      sel_next     = sel_reg;
      penable_next = penable_reg;
      pwrite_next  = pwrite_reg;
      paddr_next   = paddr_reg;
      pwdata_next  = pwdata_reg;
      tcnt_next    = tcnt_reg;
      err_next     = err_reg;
      err_inc      = 1'b0;

      case (state_reg)
         ST_IDLE: begin
            if (m_psel && !m_penable) begin
               idx_next    = req_idx;
               pwrite_next = m_pwrite;
               paddr_next  = m_paddr;
               pwdata_next = m_pwdata;
               tcnt_next   = '0;
               if (req_in_range) begin
                  state_next = ST_SETUP;
                  sel_next   = req_hit;
               end else begin
                  state_next = ST_DEC_ERR;
                  err_inc    = 1'b1;
               end
            end
         end
         ST_SETUP: begin
            if (!m_psel) begin
               state_next   = ST_IDLE;
               sel_next     = '0;
               penable_next = 1'b0;
            end else begin
               state_next   = ST_ACCESS;
               penable_next = 1'b1;
            end
         end
         ST_ACCESS: begin
            if (!m_psel || complete) begin
               // Master abandoning the transfer is a silent abort, not an error.
               state_next   = ST_IDLE;
               sel_next     = '0;
               penable_next = 1'b0;
               tcnt_next    = '0;
               err_inc      = timeout_hit;
            end else if (tcnt_reg != '1) begin
               tcnt_next = tcnt_reg + TCW'(1);
            end
         end
         ST_DEC_ERR: begin
            state_next = ST_IDLE;
         end
         default: begin
            state_next   = ST_IDLE;
            sel_next     = '0;
            penable_next = 1'b0;
         end
      endcase

      if (err_inc && (err_reg != 8'hFF)) begin
         err_next = err_reg + 8'd1;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_reg   <= ST_IDLE;
         idx_reg     <= '0;
         sel_reg     <= '0;
         penable_reg <= 1'b0;
         pwrite_reg  <= 1'b0;
         paddr_reg   <= '0;
         pwdata_reg  <= '0;
         tcnt_reg    <= '0;
         err_reg     <= '0;
      end else begin
         state_reg   <= state_next;
         idx_reg     <= idx_next;
         sel_reg     <= sel_next;
         penable_reg <= penable_next;
         pwrite_reg  <= pwrite_next;
         paddr_reg   <= paddr_next;
         pwdata_reg  <= pwdata_next;
         tcnt_reg    <= tcnt_next;
         err_reg     <= err_next;
      end
   end

   always_comb begin
      m_pready  = 1'b0;
      m_pslverr = 1'b0;
      m_prdata  = '0;
      case (state_reg)
         ST_ACCESS: begin
            m_pready  = complete;
            m_pslverr = sel_err | timeout_hit;
            m_prdata  = sel_rdata;
         end
         ST_DEC_ERR: begin
            m_pready  = 1'b1;
            m_pslverr = 1'b1;
         end
         default: begin
            m_pready  = 1'b0;
         end
      endcase
   end

   assign s_pselx   = sel_reg;
   assign s_penable = penable_reg;
   assign s_pwrite  = pwrite_reg;
   assign s_paddr   = paddr_reg;
   assign s_pwdata  = pwdata_reg;
   assign err_count = err_reg;

endmodule

// File: tb/tb_apb_slave_router.sv
// Randomised scoreboard bench for apb_slave_router: driver pushes expected responses,
// monitor pops and compares on every master completion and slave SETUP.
module tb_apb_slave_router;

   localparam int NS      = 3;   // non power of two so idx 3 is a decode miss
   localparam int T       = 16;
   localparam int SEL_LSB = 12;

   logic              clk;
   logic              rst_n;
   logic              m_psel, m_penable, m_pwrite;
   logic [31:0]       m_paddr, m_pwdata;
   logic [31:0]       m_prdata;
   logic              m_pready, m_pslverr;
   logic [NS-1:0]     s_pselx;
   logic              s_penable, s_pwrite;
   logic [31:0]       s_paddr, s_pwdata;
   logic [NS*32-1:0]  s_prdata;
   logic [NS-1:0]     s_pready, s_pslverr;
   logic [7:0]        err_count;

   apb_slave_router #(
      .NO_OF_SLAVES(NS), .ADDR_WIDTH(32), .DATA_WIDTH(32),
      .SLV_SEL_LSB(SEL_LSB), .TIMEOUT_CYCLES(T)
   ) dut (
      .clk(clk), .rst_n(rst_n),
      .m_psel(m_psel), .m_penable(m_penable), .m_pwrite(m_pwrite),
      .m_paddr(m_paddr), .m_pwdata(m_pwdata),
      .m_prdata(m_prdata), .m_pready(m_pready), .m_pslverr(m_pslverr),
      .s_pselx(s_pselx), .s_penable(s_penable), .s_pwrite(s_pwrite),
      .s_paddr(s_paddr), .s_pwdata(s_pwdata),
      .s_prdata(s_prdata), .s_pready(s_pready), .s_pslverr(s_pslverr),
      .err_count(err_count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   typedef struct {
      int          lat;
      logic        err;
      logic [31:0] rdata;
      logic [7:0]  errs;
      logic        has_slave;
      logic [NS-1:0] sel;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic        write;
   } exp_t;

   exp_t q[$];
   int   checks = 0;
   int   failures = 0;
   int   model_errs = 0;

   // Slave behaviour knobs, set by the stimulus before each transfer.
   int          slv_wait  [NS];
   logic        slv_never [NS];
   logic        slv_err   [NS];
   logic [31:0] slv_rdata [NS];
   int          acc_cnt   [NS];
   logic [NS-1:0]    noise_rdy, noise_err;
   logic [NS*32-1:0] noise_data;

   always @(posedge clk) begin
      noise_rdy  <= NS'($urandom);
      noise_err  <= NS'($urandom);
      noise_data <= {$urandom, $urandom, $urandom};
      for (int k = 0; k < NS; k++) begin
         acc_cnt[k] <= (s_pselx[k] && s_penable) ? acc_cnt[k] + 1 : 0;
      end
   end

   // Unselected slaves babble random ready/error/data which the router must ignore.
   always_comb begin
      s_pready  = '0;
      s_pslverr = '0;
      s_prdata  = '0;
      for (int k = 0; k < NS; k++) begin
         if (s_pselx[k]) begin
            s_pready[k]          = s_penable && !slv_never[k] && (acc_cnt[k] >= slv_wait[k]);
            s_pslverr[k]         = slv_err[k];
            s_prdata[k*32 +: 32] = slv_rdata[k];
         end else begin
            s_pready[k]          = noise_rdy[k];
            s_pslverr[k]         = noise_err[k];
            s_prdata[k*32 +: 32] = noise_data[k*32 +: 32];
         end
      end
   end

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, req, $time);
      end
   endtask

   function automatic logic [7:0] sat(input int v);
      return (v > 255) ? 8'd255 : 8'(v);
   endfunction

   // Reference: what the master must see, derived from address and slave behaviour.
   function automatic exp_t build_exp(input logic [31:0] a, input logic w, input logic [31:0] d);
      exp_t e;
      int   ix;
      ix = int'(a[SEL_LSB +: 2]);
      e.addr = a; e.wdata = d; e.write = w;
      e.sel = '0; e.rdata = '0;
      if (ix >= NS) begin
         e.lat = 2; e.err = 1'b1; e.has_slave = 1'b0;
         e.errs = sat(model_errs + 1);
      end else begin
         e.has_slave = 1'b1;
         e.sel = NS'(1 << ix);
         e.rdata = slv_rdata[ix];
         if (slv_never[ix]) begin
            e.lat = T + 3; e.err = 1'b1; e.errs = sat(model_errs + 1);
         end else begin
            e.lat = 3 + slv_wait[ix]; e.err = slv_err[ix]; e.errs = sat(model_errs);
         end
      end
      return e;
   endfunction

   task automatic cfg(input int ix, input int w, input logic never, input logic er,
                      input logic [31:0] rd);
      if (ix < NS) begin
         slv_wait[ix] = w; slv_never[ix] = never; slv_err[ix] = er; slv_rdata[ix] = rd;
      end
   endtask

   task automatic idle(input int n);
      repeat (n) begin @(posedge clk); #1; end
   endtask

   task automatic hard_reset();
      rst_n = 1'b0; m_psel = 1'b0; m_penable = 1'b0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      q.delete();
      model_errs = 0;
   endtask

   task automatic check_all_zero(input string tag);
      chk({tag, "_m_pready"},  64'(m_pready),  64'd0);
      chk({tag, "_m_pslverr"}, 64'(m_pslverr), 64'd0);
      chk({tag, "_m_prdata"},  64'(m_prdata),  64'd0);
      chk({tag, "_s_pselx"},   64'(s_pselx),   64'd0);
      chk({tag, "_s_penable"}, 64'(s_penable), 64'd0);
      chk({tag, "_s_pwrite"},  64'(s_pwrite),  64'd0);
      chk({tag, "_s_paddr"},   64'(s_paddr),   64'd0);
      chk({tag, "_s_pwdata"},  64'(s_pwdata),  64'd0);
      chk({tag, "_err_count"}, 64'(err_count), 64'd0);
   endtask

   // Called at posedge+1; leaves the bus idle at posedge+1 of the cycle after completion.
   task automatic xfer(input logic [31:0] a, input logic w, input logic [31:0] d);
      exp_t e;
      bit   got;
      e = build_exp(a, w, d);
      model_errs = int'(e.errs);
      q.push_back(e);
      m_psel = 1'b1; m_penable = 1'b0; m_paddr = a; m_pwrite = w; m_pwdata = d;
      @(posedge clk); #1;
      m_penable = 1'b1;
      got = 1'b0;
      for (int n = 0; n < 64 && !got; n++) begin
         @(negedge clk);
         got = m_pready;
      end
      @(posedge clk); #1;
      m_psel = 1'b0; m_penable = 1'b0;
      if (!got) begin
         chk("pready_bound", 64'(m_pready), 64'd1);
         hard_reset();
      end
   endtask

   initial begin : monitor
      exp_t e;
      int   cyc;
      bit   pend;
      bit   seen;
      logic [7:0] pend_errs;
      cyc = 0; pend = 1'b0; seen = 1'b0; pend_errs = '0;
      forever begin
         @(negedge clk);
         if (pend) begin
            chk("err_count", 64'(err_count), 64'(pend_errs));
            chk("pselx_cleared", 64'(s_pselx), 64'd0);
            chk("penable_cleared", 64'(s_penable), 64'd0);
            pend = 1'b0;
         end
         chk("pselx_onehot0", 64'($onehot0(s_pselx)), 64'd1);
         if (m_psel && !m_penable) begin
            cyc = 1; seen = 1'b0;
         end else if (m_psel) begin
            cyc++;
         end
         if ((|s_pselx) && !s_penable) begin
            if (q.size() == 0 || !q[0].has_slave) begin
               chk("unexpected_select", 64'(s_pselx), 64'd0);
            end else begin
               chk("slave_sel",   64'(s_pselx),  64'(q[0].sel));
               chk("slave_addr",  64'(s_paddr),  64'(q[0].addr));
               chk("slave_wdata", 64'(s_pwdata), 64'(q[0].wdata));
               chk("slave_write", 64'(s_pwrite), 64'(q[0].write));
               seen = 1'b1;
            end
         end
         if (m_psel && m_pready) begin
            if (q.size() == 0) begin
               chk("unexpected_pready", 64'(m_pready), 64'd0);
            end else begin
               e = q.pop_front();
               chk("latency",   64'(cyc),       64'(e.lat));
               chk("pslverr",   64'(m_pslverr), 64'(e.err));
               chk("prdata",    64'(m_prdata),  64'(e.rdata));
               chk("slave_seen", 64'(seen),     64'(e.has_slave));
               $display("txn addr=%08h write=%0d lat=%0d pslverr=%0d prdata=%08h",
                        e.addr, e.write, cyc, m_pslverr, m_prdata);
               pend = 1'b1;
               pend_errs = e.errs;
            end
         end
      end
   end

   initial begin : watchdog
      #2_000_000;
      $display("FAIL watchdog actual=running required=finished");
      $fatal(1, "watchdog expired");
   end

   initial begin : stim
      logic [31:0] a;
      int          ix;
      rst_n = 1'b0;
      m_psel = 1'b0; m_penable = 1'b0; m_pwrite = 1'b0; m_paddr = '0; m_pwdata = '0;
      for (int k = 0; k < NS; k++) cfg(k, 0, 1'b0, 1'b0, 32'h0);
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_all_zero("reset");
      @(posedge clk); #1;
      rst_n = 1'b1;
      idle(1);

      // Zero-wait write, 2-wait read, decode miss, timeout.
      cfg(2, 0, 1'b0, 1'b0, 32'h1111_2222);
      xfer(32'h0000_2004, 1'b1, 32'hA5A5_0001);
      idle(1);
      cfg(1, 2, 1'b0, 1'b0, 32'hDEAD_BEEF);
      xfer(32'h0000_1000, 1'b0, 32'h0);
      idle(2);
      xfer(32'h0000_3000, 1'b0, 32'h0);
      cfg(0, 0, 1'b1, 1'b0, 32'h0BAD_F00D);
      xfer(32'h0000_0010, 1'b0, 32'h0);

      // Back-to-back to slaves 0 then 2, second one reporting a slave error.
      cfg(0, 0, 1'b0, 1'b0, 32'h0000_0A0A);
      cfg(2, 1, 1'b0, 1'b1, 32'h0000_2B2B);
      xfer(32'h0000_0020, 1'b1, 32'h0000_0001);
      xfer(32'h0000_2020, 1'b1, 32'h0000_0002);
      idle(1);

      // Reset asserted while the master is still in ACCESS.
      cfg(0, 0, 1'b1, 1'b0, 32'h5555_AAAA);
      q.push_back(build_exp(32'h0000_0040, 1'b1, 32'h0000_CAFE));
      m_psel = 1'b1; m_penable = 1'b0; m_paddr = 32'h0000_0040; m_pwrite = 1'b1; m_pwdata = 32'h0000_CAFE;
      @(posedge clk); #1;
      m_penable = 1'b1;
      idle(3);
      rst_n = 1'b0;
      @(posedge clk); #1;
      m_psel = 1'b0; m_penable = 1'b0; rst_n = 1'b1;
      @(negedge clk);
      check_all_zero("midreset");
      q.delete();
      model_errs = 0;
      @(posedge clk); #1;
      cfg(0, 1, 1'b0, 1'b0, 32'h1357_9BDF);
      xfer(32'h0000_0044, 1'b0, 32'h0);
      idle(1);

      // Master drops psel in ACCESS: silent abort.
      cfg(1, 0, 1'b1, 1'b0, 32'h0);
      q.push_back(build_exp(32'h0000_1080, 1'b0, 32'h0));
      m_psel = 1'b1; m_penable = 1'b0; m_paddr = 32'h0000_1080; m_pwrite = 1'b0;
      @(posedge clk); #1;
      m_penable = 1'b1;
      idle(1);
      @(posedge clk); #1;
      m_psel = 1'b0; m_penable = 1'b0;
      @(negedge clk);
      chk("abort_no_pready", 64'(m_pready), 64'd0);
      @(negedge clk);
      chk("abort_pselx", 64'(s_pselx), 64'd0);
      chk("abort_penable", 64'(s_penable), 64'd0);
      chk("abort_err_count", 64'(err_count), 64'(model_errs));
      q.delete();
      @(posedge clk); #1;

      // Randomised traffic.
      for (int i = 0; i < 150; i++) begin
         a = $urandom;
         ix = int'(a[SEL_LSB +: 2]);
         cfg(ix, int'($urandom_range(0, 6)), ($urandom_range(0, 9) == 0),
             ($urandom_range(0, 3) == 0), $urandom);
         xfer(a, 1'($urandom_range(0, 1)), $urandom);
         if ($urandom_range(0, 2) == 0) idle(int'($urandom_range(1, 3)));
      end

      // Drive err_count into saturation with back-to-back decode misses.
      for (int i = 0; i < 260; i++) begin
         a = $urandom;
         a[SEL_LSB +: 2] = 2'b11;
         xfer(a, 1'($urandom_range(0, 1)), $urandom);
      end
      @(negedge clk);
      chk("err_saturated", 64'(err_count), 64'd255);
      idle(2);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
